cmd_cfg_multi: RTL and testbench
================================

# cmd_cfg_multi

Parametrised command decoder and flight-configuration register file for the quadcopter flight controller. It sits between the UART command receiver and the flight controller. It decodes 8-bit opcodes into a configurable number of signed attitude setpoint channels and a saturating thrust register. It also sequences battery conversion and motor spin-up/inertial calibration, and returns a one-byte response (ACK, NAK or battery level) to the UART response wrapper.

## Interface
- NUM_SP, 3, number of setpoint channels (ch0 = pitch, ch1 = roll, ch2 = yaw, further channels are auxiliary); range 1..16
- DATA_W, 16, command data width; setpoints are signed DATA_W
- THRST_W, 9, thrust width (unsigned)
- TMR_W, 26, spin-up timer width; spin-up wait lasts 2^TMR_W-1 cycles
- WDOG_W, 26, watchdog counter width (used only with CMD_WDOG_EN)
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- cmd_rdy  input  1  a new command and its data are valid
- cmd  input  8  opcode
- data  input  DATA_W  command payload
- batt  input  8  battery level from the A2D interface
- cnv_cmplt  input  1  battery conversion complete
- cal_done  input  1  inertial calibration complete
- clr_cmd_rdy  output  1  consume command (combinational)
- snd_rsp  output  1  one-cycle response strobe (registered)
- resp  output  8  response byte (registered; holds its value between strobes)
- sp  output  NUM_SP*DATA_W  flattened setpoints; channel n occupies bits [n*DATA_W +: DATA_W]
- thrst  output  THRST_W  thrust
- strt_cnv  output  1  one-cycle battery conversion start
- strt_cal  output  1  one-cycle calibration start
- inertial_cal  output  1  calibration in progress
- motors_off  output  1  motor kill
- busy  output  1  FSM not in IDLE

## Operation
- Opcodes:
  - 0x1n SET_SP: channel n, where n < NUM_SP; otherwise NAK.
  - 0x20 SET_THRST
  - 0x30 REQ_BATT
  - 0x40 CALIBRATE
  - 0x50 EMER_LAND
  - 0x60 MTRS_OFF
  - Any other opcode: NAK.
- Response codes: ACK = 0xA5, NAK = 0xEE, battery request returns the batt byte.
- FSM states: IDLE, BATT, CAL_SPIN, CAL_WAIT, RESP.
- IDLE with cmd_rdy: clr_cmd_rdy=1 the same cycle.
  - SET_SP, SET_THRST, EMER_LAND, MTRS_OFF and NAK: the register side effect lands at the next edge, then go to RESP.
  - REQ_BATT: strt_cnv=1 the same cycle, then go to BATT.
  - CALIBRATE: clear motors_off, clear the spin-up timer, then go to CAL_SPIN.
- cmd_rdy is neither cleared nor decoded outside IDLE.
- SET_THRST: thrst = data[THRST_W-1:0] when data < 2^THRST_W. Otherwise thrst saturates to all-ones. Negative data (MSB set) loads 0.
- EMER_LAND: all setpoints and thrst load 0. motors_off is unchanged.
- MTRS_OFF: motors_off=1. Setpoints and thrst are retained.
- BATT: wait for cnv_cmplt. Then resp=batt and snd_rsp=1 on the next cycle, then return to IDLE (no ACK).
- CAL_SPIN: the timer counts up. On full: strt_cal pulses for one cycle, inertial_cal is set, go to CAL_WAIT.
- CAL_WAIT: inertial_cal stays high until cal_done. On cal_done: inertial_cal=0, go to RESP with ACK.
- RESP: snd_rsp=1 with resp=ACK/NAK for one cycle, then go to IDLE.

## Timing
- Reset values:
  - state IDLE
  - sp, thrst, resp, all strobes and inertial_cal: 0
  - motors_off: 1 (motors must be explicitly enabled by CALIBRATE)
- Latency from cmd_rdy sampled in IDLE at cycle N:
  - Register writes are visible at N+1.
  - ACK/NAK snd_rsp is high in cycle N+1.
  - Minimum spacing between consecutive commands is 2 cycles.
- cnv_cmplt seen in cycle M: snd_rsp and resp=batt are valid in M+1.
- cnv_cmplt or cal_done arriving while the FSM is in another state is ignored (not latched).
- Asynchronous reset mid-calibration or mid-conversion returns to IDLE with motors_off=1 and no response sent.
- The timer is 2^TMR_W-1 cycles from the CALIBRATE decode to the strt_cal pulse.

## Configuration
- CMD_WDOG_EN defined:
  - A WDOG_W-bit counter runs while motors_off=0. It clears on every clr_cmd_rdy.
  - On all-ones, all setpoints and thrst are forced to 0 (same as EMER_LAND), with no response sent, and the counter clears.
  - If cmd_rdy is accepted in the same cycle as expiry, the command wins and the watchdog action is suppressed.
  - The watchdog action is suppressed while the FSM is in CAL_SPIN or CAL_WAIT.
- CMD_WDOG_EN undefined: no watchdog counter or logic is generated, and setpoints change only by command.

## Test plan
- Reset, then cmd=0x11, data=0xFF38 -> clr_cmd_rdy the same cycle. Next cycle sp ch1=0xFF38 and snd_rsp with resp=0xA5. Other channels stay 0.
- cmd=0x20 with data=0x0300 -> thrst=0x1FF. Then data=0x00C8 -> thrst=0x0C8. Then data=0x8000 -> thrst=0.
- cmd=0x30 -> strt_cnv pulses for one cycle. With batt=0x7B and cnv_cmplt asserted 5 cycles later -> resp=0x7B and snd_rsp one cycle later. busy is high throughout.
- With TMR_W=4: cmd=0x40 -> motors_off=0, then strt_cal after 15 cycles with inertial_cal held. cmd_rdy pulsed during CAL_WAIT is not cleared. cal_done -> ACK, then the pending command is decoded in IDLE.
- cmd=0x13 with NUM_SP=3, and cmd=0x7F -> resp=0xEE each time, registers unchanged. cmd=0x50 after setpoint writes -> all sp and thrst = 0, ACK.
- CMD_WDOG_EN with WDOG_W=5, motors on, thrst=0x100 -> no command for 31 cycles forces thrst=0 and sp=0 with no snd_rsp. A repeat run with cmd_rdy on the expiry cycle executes the command instead.

Source files
------------

// File: rtl/cmd_cfg_multi_if.sv
// Command/response handshake between the UART command path and cmd_cfg_multi.
// master: UART side (presents commands, receives responses)
// slave : the decoder (consumes commands, returns response bytes)
interface cmd_cfg_multi_if #(
    parameter int DATA_W = 16
);
    logic              cmd_rdy;
    logic [7:0]        cmd;
    logic [DATA_W-1:0] data;
    logic              clr_cmd_rdy;
    logic              snd_rsp;
    logic [7:0]        resp;

    modport master (
        output cmd_rdy, cmd, data,
        input  clr_cmd_rdy, snd_rsp, resp
    );

    modport slave (
        input  cmd_rdy, cmd, data,
        output clr_cmd_rdy, snd_rsp, resp
    );
endinterface

// File: rtl/cmd_cfg_multi.sv
// Quadcopter command decoder and flight-configuration register file.
// Decodes 8-bit opcodes into signed setpoint channels and a saturating thrust
// register, sequences battery conversion and motor spin-up/calibration, and
// returns ACK/NAK/battery bytes to the UART response path.
// Optional build macro: CMD_WDOG_EN adds a command-silence watchdog that
// zeroes setpoints and thrust while the motors are running.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for cmd_rdy; the only state that decodes commands
// BATT     | conversion started, waiting for cnv_cmplt
// CAL_SPIN | motors spinning up, spin-up timer counting
// CAL_WAIT | inertial calibration running, waiting for cal_done
// RESP     | response strobe cycle for ACK/NAK
module cmd_cfg_multi #(
    parameter int NUM_SP  = 3,
    parameter int DATA_W  = 16,
    parameter int THRST_W = 9,
    parameter int TMR_W   = 26,
    parameter int WDOG_W  = 26
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cmd_cfg_multi_if.slave           bus,
    input  logic [7:0]               batt,
    input  logic                     cnv_cmplt,
    input  logic                     cal_done,
    output logic [NUM_SP*DATA_W-1:0] sp,
    output logic [THRST_W-1:0]       thrst,
    output logic                     strt_cnv,
    output logic                     strt_cal,
    output logic                     inertial_cal,
    output logic                     motors_off,
    output logic                     busy
);

    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;
    localparam logic [7:0] OP_THRST = 8'h20;
    localparam logic [7:0] OP_BATT  = 8'h30;
    localparam logic [7:0] OP_CAL   = 8'h40;
    localparam logic [7:0] OP_LAND  = 8'h50;
    localparam logic [7:0] OP_OFF   = 8'h60;
    localparam logic [4:0] NSP5     = 5'(NUM_SP);
    localparam logic [DATA_W-1:0] THR_MAX = DATA_W'((1 << THRST_W) - 1);
    // timer value one count before full: the strobe registers as the counter wraps to all-ones
    localparam logic [TMR_W-1:0]  TMR_LAST = {{(TMR_W-1){1'b1}}, 1'b0};

    if (NUM_SP < 1 || NUM_SP > 16 || THRST_W >= DATA_W || TMR_W < 2 || WDOG_W < 2) begin : g_bad_param
        $error("cmd_cfg_multi: parameter out of range");
    end

    typedef enum logic [2:0] {IDLE, BATT, CAL_SPIN, CAL_WAIT, RESP} state_t;

    state_t            state;
    logic [DATA_W-1:0] sp_r [NUM_SP];
    logic [TMR_W-1:0]  tmr;
    logic              accept;
    logic              sp_hit;
    logic [THRST_W-1:0] thr_sat;

    assign accept          = (state == IDLE) && bus.cmd_rdy;
    assign bus.clr_cmd_rdy = accept;
    assign strt_cnv        = accept && (bus.cmd == OP_BATT);
    assign busy            = (state != IDLE);
    assign sp_hit          = (bus.cmd[7:4] == 4'h1) && ({1'b0, bus.cmd[3:0]} < NSP5);

    for (genvar g = 0; g < NUM_SP; g++) begin : g_sp
        assign sp[g*DATA_W +: DATA_W] = sp_r[g];
    end

    // thrust loads clamp: negative payload to 0, oversize payload to all-ones
    always_comb begin
        if (bus.data[DATA_W-1])
            thr_sat = '0;
        else if (bus.data > THR_MAX)
            thr_sat = '1;
        else
            thr_sat = bus.data[THRST_W-1:0];
    end

`ifdef CMD_WDOG_EN
    logic [WDOG_W-1:0] wd_cnt;
    logic              wd_fire;

    // a command accepted on the expiry cycle wins; calibration is never interrupted
    assign wd_fire = (&wd_cnt) && !accept && (state != CAL_SPIN) && (state != CAL_WAIT);

    // silence counter: runs with motors on, restarts on every accepted command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt <= '0;
        else if (motors_off || accept || (&wd_cnt))
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end
`endif

    // main sequencer with registered strobes, response byte and register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            for (int i = 0; i < NUM_SP; i++) sp_r[i] <= '0;
            thrst        <= '0;
            bus.resp     <= '0;
            bus.snd_rsp  <= 1'b0;
            strt_cal     <= 1'b0;
            inertial_cal <= 1'b0;
            motors_off   <= 1'b1;
            tmr          <= '0;
        end else begin
            bus.snd_rsp <= 1'b0;
            strt_cal    <= 1'b0;
`ifdef CMD_WDOG_EN
            if (wd_fire) begin
                for (int i = 0; i < NUM_SP; i++) sp_r[i] <= '0;
                thrst <= '0;
            end
`endif
            case (state)
                IDLE: begin
                    if (bus.cmd_rdy) begin
                        state       <= RESP;
                        bus.snd_rsp <= 1'b1;
                        bus.resp    <= ACK;
                        if (sp_hit) begin
                            for (int i = 0; i < NUM_SP; i++)
                                if (bus.cmd[3:0] == 4'(i)) sp_r[i] <= bus.data;
                        end else begin
                            case (bus.cmd)
                                OP_THRST: thrst <= thr_sat;
                                OP_BATT: begin
                                    state       <= BATT;
                                    bus.snd_rsp <= 1'b0;
                                end
                                OP_CAL: begin
                                    state       <= CAL_SPIN;
                                    bus.snd_rsp <= 1'b0;
                                    motors_off  <= 1'b0;
                                    tmr         <= '0;
                                end
                                OP_LAND: begin
                                    for (int i = 0; i < NUM_SP; i++) sp_r[i] <= '0;
                                    thrst <= '0;
                                end
                                OP_OFF:  motors_off <= 1'b1;
                                default: bus.resp   <= NAK;
                            endcase
                        end
                    end
                end
                BATT: begin
                    if (cnv_cmplt) begin
                        bus.resp    <= batt;
                        bus.snd_rsp <= 1'b1;
                        state       <= IDLE;
                    end
                end
                CAL_SPIN: begin
                    tmr <= tmr + 1'b1;
                    if (tmr == TMR_LAST) begin
                        strt_cal     <= 1'b1;
                        inertial_cal <= 1'b1;
                        state        <= CAL_WAIT;
                    end
                end
                CAL_WAIT: begin
                    if (cal_done) begin
                        inertial_cal <= 1'b0;
                        bus.resp     <= ACK;
                        bus.snd_rsp  <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_cfg_multi.sv
// Directed bench for cmd_cfg_multi (NUM_SP=3, DATA_W=16, THRST_W=9, TMR_W=4,
// WDOG_W=5). The watchdog section is only built when CMD_WDOG_EN is defined.
module tb_cmd_cfg_multi;
    logic        clk;
    logic        rst_n;
    logic [7:0]  batt;
    logic        cnv_cmplt;
    logic        cal_done;
    logic [47:0] sp;
    logic [8:0]  thrst;
    logic        strt_cnv, strt_cal, inertial_cal, motors_off, busy;

    int tests = 0;
    int fails = 0;
    int cnt;

    cmd_cfg_multi_if #(.DATA_W(16)) bus_if ();

    cmd_cfg_multi #(
        .NUM_SP(3), .DATA_W(16), .THRST_W(9), .TMR_W(4), .WDOG_W(5)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_if),
        .batt(batt), .cnv_cmplt(cnv_cmplt), .cal_done(cal_done),
        .sp(sp), .thrst(thrst), .strt_cnv(strt_cnv), .strt_cal(strt_cal),
        .inertial_cal(inertial_cal), .motors_off(motors_off), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ch(input int n);
        return sp[n*16 +: 16];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // drive a command at the current negedge (cycle N), return at negedge of N+1
    task automatic send(input logic [7:0] c, input logic [15:0] d, input string tag);
        bus_if.cmd_rdy = 1'b1;
        bus_if.cmd     = c;
        bus_if.data    = d;
        #1 chk({tag, "_clr"}, 32'(bus_if.clr_cmd_rdy), 32'd1);
        @(posedge clk);
        #1 bus_if.cmd_rdy = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus_if.cmd_rdy = 1'b0;
        bus_if.cmd = 8'h00;
        bus_if.data = 16'h0000;
        batt = 8'h00;
        cnv_cmplt = 1'b0;
        cal_done = 1'b0;
        repeat (3) step();
        chk("rst_sp", 32'(sp), 32'd0);
        chk("rst_thrst", 32'(thrst), 32'd0);
        chk("rst_resp", 32'(bus_if.resp), 32'd0);
        chk("rst_snd", 32'(bus_if.snd_rsp), 32'd0);
        chk("rst_moff", 32'(motors_off), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ical", 32'(inertial_cal), 32'd0);
        rst_n = 1'b1;
        step();

        // setpoint write to channel 1
        send(8'h11, 16'hFF38, "sp1");
        chk("sp1_ch1", 32'(ch(1)), 32'hFF38);
        chk("sp1_ch0", 32'(ch(0)), 32'h0);
        chk("sp1_ch2", 32'(ch(2)), 32'h0);
        chk("sp1_snd", 32'(bus_if.snd_rsp), 32'd1);
        chk("sp1_resp", 32'(bus_if.resp), 32'hA5);
        step();
        chk("sp1_snd_low", 32'(bus_if.snd_rsp), 32'd0);
        chk("sp1_resp_hold", 32'(bus_if.resp), 32'hA5);
        chk("sp1_busy", 32'(busy), 32'd0);

        // thrust saturation and clamping
        send(8'h20, 16'h0300, "thr_sat");
        chk("thr_sat", 32'(thrst), 32'h1FF);
        step();
        send(8'h20, 16'h00C8, "thr_mid");
        chk("thr_mid", 32'(thrst), 32'h0C8);
        step();
        send(8'h20, 16'h8000, "thr_neg");
        chk("thr_neg", 32'(thrst), 32'h000);
        step();
        send(8'h20, 16'h01FF, "thr_max");
        chk("thr_max", 32'(thrst), 32'h1FF);
        step();

        // NAK paths leave registers untouched
        send(8'h10, 16'h0123, "sp0");
        step();
        send(8'h20, 16'h0055, "thr55");
        step();
        send(8'h13, 16'h1234, "nak13");
        chk("nak13_resp", 32'(bus_if.resp), 32'hEE);
        chk("nak13_snd", 32'(bus_if.snd_rsp), 32'd1);
        chk("nak13_sp", 32'(sp), {16'h0000, 16'h0000, 16'hFF38, 16'h0123} & 32'hFFFFFFFF);
        chk("nak13_ch2", 32'(ch(2)), 32'h0);
        step();
        send(8'h7F, 16'h5555, "nak7f");
        chk("nak7f_resp", 32'(bus_if.resp), 32'hEE);
        chk("nak7f_thr", 32'(thrst), 32'h055);
        step();

        // emergency land zeroes everything but leaves motors_off alone
        send(8'h50, 16'h0000, "land");
        chk("land_sp", 32'(sp), 32'd0);
        chk("land_ch2", 32'(ch(2)), 32'd0);
        chk("land_thr", 32'(thrst), 32'd0);
        chk("land_resp", 32'(bus_if.resp), 32'hA5);
        chk("land_moff", 32'(motors_off), 32'd1);
        step();

        // battery request
        batt = 8'h7B;
        bus_if.cmd_rdy = 1'b1;
        bus_if.cmd = 8'h30;
        #1 chk("batt_cnv", 32'(strt_cnv), 32'd1);
        chk("batt_clr", 32'(bus_if.clr_cmd_rdy), 32'd1);
        @(posedge clk);
        #1 bus_if.cmd_rdy = 1'b0;
        step();
        chk("batt_cnv_pulse", 32'(strt_cnv), 32'd0);
        cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            if (!busy || bus_if.snd_rsp) cnt++;
            if (k < 5) step();
        end
        chk("batt_wait", 32'(cnt), 32'd0);
        cnv_cmplt = 1'b1;
        @(posedge clk);
        #1 cnv_cmplt = 1'b0;
        step();
        chk("batt_snd", 32'(bus_if.snd_rsp), 32'd1);
        chk("batt_resp", 32'(bus_if.resp), 32'h7B);
        step();
        chk("batt_snd_low", 32'(bus_if.snd_rsp), 32'd0);

        // stray conversion complete while idle is ignored
        cnv_cmplt = 1'b1;
        batt = 8'h11;
        step();
        cnv_cmplt = 1'b0;
        step();
        chk("stray_cnv_snd", 32'(bus_if.snd_rsp), 32'd0);
        chk("stray_cnv_resp", 32'(bus_if.resp), 32'h7B);

        // calibration: 15-cycle spin-up, command held off during CAL_WAIT
        send(8'h40, 16'h0000, "cal");
        chk("cal_moff", 32'(motors_off), 32'd0);
        chk("cal_busy", 32'(busy), 32'd1);
        chk("cal_nosnd", 32'(bus_if.snd_rsp), 32'd0);
        cnt = 0;
        for (int k = 1; k <= 15; k++) begin
            if (strt_cal || inertial_cal) cnt++;
            cal_done = (k == 5);
            step();
        end
        cal_done = 1'b0;
        chk("cal_early", 32'(cnt), 32'd0);
        chk("cal_strt", 32'(strt_cal), 32'd1);
        chk("cal_ical", 32'(inertial_cal), 32'd1);
        step();
        chk("cal_strt_pulse", 32'(strt_cal), 32'd0);
        chk("cal_ical_hold", 32'(inertial_cal), 32'd1);
        bus_if.cmd_rdy = 1'b1;
        bus_if.cmd = 8'h11;
        bus_if.data = 16'h4444;
        #1 chk("calw_noclr", 32'(bus_if.clr_cmd_rdy), 32'd0);
        repeat (3) step();
        chk("calw_noclr2", 32'(bus_if.clr_cmd_rdy), 32'd0);
        chk("calw_ical", 32'(inertial_cal), 32'd1);
        chk("calw_ch1", 32'(ch(1)), 32'd0);
        cal_done = 1'b1;
        @(posedge clk);
        #1 cal_done = 1'b0;
        step();
        chk("cald_snd", 32'(bus_if.snd_rsp), 32'd1);
        chk("cald_resp", 32'(bus_if.resp), 32'hA5);
        chk("cald_ical", 32'(inertial_cal), 32'd0);
        chk("cald_noclr", 32'(bus_if.clr_cmd_rdy), 32'd0);
        step();
        chk("pend_clr", 32'(bus_if.clr_cmd_rdy), 32'd1);
        @(posedge clk);
        #1 bus_if.cmd_rdy = 1'b0;
        step();
        chk("pend_ch1", 32'(ch(1)), 32'h4444);
        chk("pend_snd", 32'(bus_if.snd_rsp), 32'd1);
        step();

`ifdef CMD_WDOG_EN
        // silence watchdog expiry
        send(8'h20, 16'h0100, "wd_thr");
        chk("wd_thr", 32'(thrst), 32'h100);
        repeat (31) step();
        chk("wd_before", 32'(thrst), 32'h100);
        step();
        chk("wd_thr0", 32'(thrst), 32'h0);
        chk("wd_sp0", 32'(sp), 32'd0);
        chk("wd_nosnd", 32'(bus_if.snd_rsp), 32'd0);
        step();
        // command on expiry cycle wins
        send(8'h20, 16'h0100, "wd2_thr");
        repeat (31) step();
        send(8'h20, 16'h0050, "wd2_cmd");
        chk("wd2_thr", 32'(thrst), 32'h050);
        chk("wd2_snd", 32'(bus_if.snd_rsp), 32'd1);
        step();
`else
        // no watchdog: long silence keeps registers
        repeat (40) step();
        chk("nowd_ch1", 32'(ch(1)), 32'h4444);
        chk("nowd_snd", 32'(bus_if.snd_rsp), 32'd0);
`endif

        // motors off keeps setpoints
        send(8'h12, 16'h7FFF, "sp2");
        chk("sp2_ch2", 32'(ch(2)), 32'h7FFF);
        step();
        send(8'h60, 16'h0000, "off");
        chk("off_moff", 32'(motors_off), 32'd1);
        chk("off_ch2", 32'(ch(2)), 32'h7FFF);
        chk("off_resp", 32'(bus_if.resp), 32'hA5);
        step();

        // asynchronous reset during spin-up
        send(8'h40, 16'h0000, "cal2");
        chk("cal2_moff", 32'(motors_off), 32'd0);
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1 chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_moff", 32'(motors_off), 32'd1);
        chk("arst_sp", 32'(sp), 32'd0);
        step();
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus_if.snd_rsp || strt_cal || busy) cnt++;
            step();
        end
        chk("arst_quiet", 32'(cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
